// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: handshaked output-stationary N_SIZE x N_SIZE systolic matrix multiplier
module systolic_mm_engine #(
    parameter int DATAWIDTH = 8,
    parameter int N_SIZE    = 4,
    parameter int K_MAX     = 16,
    parameter int ACCWIDTH  = 2*DATAWIDTH+$clog2(K_MAX),
    parameter int SIGNED    = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [$clog2(K_MAX+1)-1:0]    k_len,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_SIZE*DATAWIDTH-1:0]   a_vec,
    input  logic [N_SIZE*DATAWIDTH-1:0]   b_vec,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(N_SIZE)-1:0]     out_row,
    output logic [N_SIZE*ACCWIDTH-1:0]    c_row,
    output logic                          busy,
    output logic                          done
);
    localparam int KW = $clog2(K_MAX+1);
    localparam int RW = $clog2(N_SIZE);
    localparam int PW = 2*DATAWIDTH;
    localparam int FW = $clog2(2*N_SIZE);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;
    state_t state;
    logic [KW-1:0] k_reg, cnt, k_clamp;
    logic [FW-1:0] fcnt;
    logic [RW-1:0] row;
    logic clr, en, beat;
    logic [N_SIZE-1:0][N_SIZE-1:0][DATAWIDTH-1:0] a_h, b_v;
    logic [N_SIZE-1:0][N_SIZE-1:0][ACCWIDTH-1:0] acc_w;

    assign k_clamp = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
    assign clr     = (state == IDLE) && start;
    assign en      = (state == LOAD) || (state == FLUSH);
    assign beat    = in_valid && in_ready;
    assign busy    = state != IDLE;
    assign out_row = row;
    assign c_row   = out_valid ? acc_w[row] : '0;

    // job control: capture K, count accepted beats and flush cycles, step the drain row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k_reg     <= '0;
            cnt       <= '0;
            fcnt      <= '0;
            row       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    k_reg     <= k_clamp;
                    cnt       <= '0;
                    row       <= '0;
                    in_ready  <= k_clamp != '0;
                    out_valid <= k_clamp == '0;
                    state     <= (k_clamp == '0) ? DRAIN : LOAD;
                end
                LOAD: if (beat) begin
                    cnt <= cnt + KW'(1);
                    if (cnt + KW'(1) == k_reg) begin
                        in_ready <= 1'b0;
                        fcnt     <= '0;
                        state    <= FLUSH;
                    end
                end
                FLUSH: begin
                    fcnt <= fcnt + FW'(1);
                    if (fcnt == FW'(2*N_SIZE-2)) begin
                        out_valid <= 1'b1;
                        state     <= DRAIN;
                    end
                end
                DRAIN: if (out_ready) begin
                    if (row == RW'(N_SIZE-1)) begin
                        row       <= '0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        row <= row + RW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N_SIZE; i++) begin : g_skew
        logic [DATAWIDTH-1:0] a_inj, b_inj;
        assign a_inj = beat ? a_vec[i*DATAWIDTH +: DATAWIDTH] : '0;
        assign b_inj = beat ? b_vec[i*DATAWIDTH +: DATAWIDTH] : '0;
        if (i == 0) begin : g_direct
            assign a_h[0][0] = a_inj;
            assign b_v[0][0] = b_inj;
        end else begin : g_delay
            logic [DATAWIDTH-1:0] a_sr [i];
            logic [DATAWIDTH-1:0] b_sr [i];
            // i-stage skew lines so row i / column i meet their partners on the diagonal wavefront
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < i; s++) begin
                        a_sr[s] <= '0;
                        b_sr[s] <= '0;
                    end
                end else begin
                    a_sr[0] <= clr ? '0 : a_inj;
                    b_sr[0] <= clr ? '0 : b_inj;
                    for (int s = 1; s < i; s++) begin
                        a_sr[s] <= clr ? '0 : a_sr[s-1];
                        b_sr[s] <= clr ? '0 : b_sr[s-1];
                    end
                end
            end
            assign a_h[i][0] = a_sr[i-1];
            assign b_v[0][i] = b_sr[i-1];
        end
    end

    for (genvar i = 0; i < N_SIZE; i++) begin : g_row
        for (genvar j = 0; j < N_SIZE; j++) begin : g_col
            logic [PW-1:0] sa, sb, prod;
            logic [ACCWIDTH-1:0] acc;
            assign sa   = {{DATAWIDTH{(SIGNED != 0) && a_h[i][j][DATAWIDTH-1]}}, a_h[i][j]};
            assign sb   = {{DATAWIDTH{(SIGNED != 0) && b_v[i][j][DATAWIDTH-1]}}, b_v[i][j]};
            assign prod = sa * sb;
            // accumulate only while operands can be in flight so results hold steady for the drain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) acc <= '0;
                else acc <= clr ? '0 : en ? acc + {{(ACCWIDTH-PW){(SIGNED != 0) && prod[PW-1]}}, prod} : acc;
            end
            assign acc_w[i][j] = acc;
            if (j < N_SIZE-1) begin : g_fwd_a
                logic [DATAWIDTH-1:0] a_q;
                // pass a one PE to the right
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) a_q <= '0;
                    else a_q <= clr ? '0 : a_h[i][j];
                end
                assign a_h[i][j+1] = a_q;
            end
            if (i < N_SIZE-1) begin : g_fwd_b
                logic [DATAWIDTH-1:0] b_q;
                // pass b one PE downward
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) b_q <= '0;
                    else b_q <= clr ? '0 : b_v[i][j];
                end
                assign b_v[i+1][j] = b_q;
            end
        end
    end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb_systolic_mm_engine: scoreboard bench for the systolic matrix-multiply engine (unsigned and signed instances)
module tb_systolic_mm_engine;
    localparam int N = 4, DW = 8, KM = 16, AW = 20, KW = 5;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic [N*DW-1:0] a_vec = '0, b_vec = '0;
    logic in_ready, out_valid, busy, done;
    logic s_in_ready, s_out_valid, s_busy, s_done;
    logic [1:0] out_row, s_out_row;
    logic [N*AW-1:0] c_row, s_c_row;
    logic [DW-1:0] a_m [N][32];
    logic [DW-1:0] b_m [32][N];
    logic [N*AW-1:0] exp_q [$];
    int row_q [$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    systolic_mm_engine #(.DATAWIDTH(DW), .N_SIZE(N), .K_MAX(KM), .SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .in_valid(in_valid),
        .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid),
        .out_ready(out_ready), .out_row(out_row), .c_row(c_row), .busy(busy), .done(done));

    systolic_mm_engine #(.DATAWIDTH(DW), .N_SIZE(N), .K_MAX(KM), .SIGNED(1)) u_sdut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .in_valid(in_valid),
        .in_ready(s_in_ready), .a_vec(a_vec), .b_vec(b_vec), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_row(s_out_row), .c_row(s_c_row), .busy(s_busy), .done(s_done));

    task automatic chk(input string tag, input logic [N*AW-1:0] got, input logic [N*AW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 32; k++) begin
                a_m[i][k] = mode == 0 ? DW'(i == k) : mode == 1 ? 8'd255 : mode == 2 ? 8'hFF : DW'($urandom);
                b_m[k][i] = mode == 0 ? DW'(4*k+i+1) : mode == 1 ? 8'd255 : mode == 2 ? 8'd127 : DW'($urandom);
            end
    endtask

    task automatic push_expected(input int k, input bit sgn);
        int s, ai, bi;
        logic [N*AW-1:0] r;
        for (int i = 0; i < N; i++) begin
            r = '0;
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int kk = 0; kk < k; kk++) begin
                    ai = sgn ? int'($signed(a_m[i][kk])) : int'(a_m[i][kk]);
                    bi = sgn ? int'($signed(b_m[kk][j])) : int'(b_m[kk][j]);
                    s += ai * bi;
                end
                r[j*AW +: AW] = s[AW-1:0];
            end
            exp_q.push_back(r);
            row_q.push_back(i);
        end
    endtask

    task automatic run_job(input string name, input int kl, input bit sgn, input int vpct,
                           input bit tog, input bit poke, input int exp_first, input int exp_done);
        int k, beats, hs, first, dcyc, lhs, er;
        bit held, ov, dn, bz;
        logic [N*AW-1:0] hrow, crow, er_row;
        logic [1:0] hidx, orow;
        k = kl > KM ? KM : kl;
        push_expected(k, sgn);
        beats = 0; hs = 0; first = 0; dcyc = 0; lhs = 0; held = 0; hrow = '0; hidx = '0;
        start = 1'b1;
        k_len = KW'(kl);
        @(posedge clk) #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 3000 && dcyc == 0; cyc++) begin
            ov   = sgn ? s_out_valid : out_valid;
            dn   = sgn ? s_done : done;
            bz   = sgn ? s_busy : busy;
            orow = sgn ? s_out_row : out_row;
            crow = sgn ? s_c_row : c_row;
            in_valid = (beats < kl) && ($urandom_range(99) < vpct);
            for (int i = 0; i < N; i++) begin
                a_vec[i*DW +: DW] = in_valid ? a_m[i][beats] : DW'($urandom);
                b_vec[i*DW +: DW] = in_valid ? b_m[beats][i] : DW'($urandom);
            end
            out_ready = tog ? cyc[0] : 1'b1;
            start = poke && ov;
            if (poke) k_len = 5'd7;
            if (in_valid && in_ready) beats++;
            if (dn) begin
                dcyc = cyc;
                chk({name, "_done_busy"}, bz, 0);
                chk({name, "_handshakes"}, hs, N);
                chk({name, "_done_gap"}, cyc, lhs + 1);
            end else if (ov) begin
                if (first == 0) first = cyc;
                if (held) begin
                    chk({name, "_hold_row"}, orow, hidx);
                    chk({name, "_hold_data"}, crow, hrow);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) chk({name, "_extra_row"}, 1, 0);
                    else begin
                        er_row = exp_q.pop_front();
                        er = row_q.pop_front();
                        chk({name, "_row_idx"}, orow, er);
                        chk({name, "_row_data"}, crow, er_row);
                    end
                    hs++;
                    lhs = cyc;
                    held = 0;
                end else begin
                    held = 1;
                    hrow = crow;
                    hidx = orow;
                end
            end
            @(posedge clk) #1;
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (dcyc == 0) chk({name, "_timeout"}, 0, 1);
        chk({name, "_beats"}, beats, k);
        if (exp_first != 0) begin
            chk({name, "_first_valid_cyc"}, first, exp_first);
            chk({name, "_done_cyc"}, dcyc, exp_done);
        end
        chk({name, "_idle_after"}, sgn ? s_busy : busy, 0);
        chk({name, "_rows_left"}, exp_q.size(), 0);
        exp_q.delete();
        row_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_c_row", c_row, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        fill(0); run_job("ident", 4, 0, 100, 0, 0, 12, 16);
        fill(1); run_job("max", 16, 0, 100, 0, 0, 0, 0);
        fill(2); run_job("signed", 2, 1, 100, 0, 0, 0, 0);
        fill(3); run_job("bp", 8, 0, 50, 1, 0, 0, 0);
        fill(3); run_job("bp_signed", 8, 1, 50, 1, 0, 0, 0);
        start = 1'b1;
        k_len = 5'd5;
        @(posedge clk) #1;
        start = 1'b0;
        in_valid = 1'b1;
        repeat (2) begin
            a_vec = $urandom;
            b_vec = $urandom;
            @(posedge clk) #1;
        end
        chk("midload_ready", in_ready, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_row", out_row, 0);
        chk("midrst_c_row", c_row, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_s_busy", s_busy, 0);
        in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        fill(3); run_job("post_rst", 3, 0, 100, 0, 0, 0, 0);
        fill(3); run_job("k_zero", 0, 0, 100, 0, 0, 1, 5);
        fill(3); run_job("poke", 5, 0, 100, 1, 1, 0, 0);
        fill(3); run_job("clamp", 31, 0, 100, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_mm_engine.md
# systolic_mm_engine

Parameterised, handshaked output-stationary systolic matrix-multiply engine computing C = A·B for an N_SIZE×K by K×N_SIZE operand pair, with the inner dimension K set at run time up to K_MAX. The block is the next-generation compute core of the accelerator datapath. Compared with the fixed-schedule array it replaces, it adds:
- ready/valid flow control on input and output, with bubbles tolerated;
- a run-time K and a start/done job protocol;
- signed/unsigned operands and a widened accumulator;
- a backpressured row-by-row result drain.

## Interface
- DATAWIDTH, 8, operand element width.
- N_SIZE, 4, array dimension (N_SIZE×N_SIZE PEs), ≥2.
- K_MAX, 16, maximum inner dimension per job.
- ACCWIDTH, 2*DATAWIDTH+$clog2(K_MAX), accumulator/result element width.
- SIGNED, 0, 1 = operands and products two's-complement; 0 = unsigned.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  job start pulse; sampled only in IDLE.
- k_len  in  $clog2(K_MAX+1)  inner dimension K; captured with start; values >K_MAX are clamped to K_MAX.
- in_valid  in  1  a_vec/b_vec beat valid.
- in_ready  out  1  engine accepts beat.
- a_vec  in  N_SIZE*DATAWIDTH  column k of A; element i at [i*DATAWIDTH +: DATAWIDTH].
- b_vec  in  N_SIZE*DATAWIDTH  row k of B; element j at [j*DATAWIDTH +: DATAWIDTH].
- out_valid  out  1  c_row holds a result row.
- out_ready  in  1  consumer accepts row.
- out_row  out  $clog2(N_SIZE)  index of the row on c_row.
- c_row  out  N_SIZE*ACCWIDTH  C[out_row][j] at [j*ACCWIDTH +: ACCWIDTH].
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse after the last row is accepted.

## Operation
- FSM with four states: IDLE, LOAD, FLUSH, DRAIN.
- **IDLE → LOAD:** on start.
  - Captures k_len and clears all PE accumulators and skew registers.
  - If k_len = 0, goes IDLE → DRAIN directly and drains all-zero rows.
- **LOAD:**
  - in_ready = 1 while the beat count < K.
  - A beat is accepted when in_valid && in_ready.
  - Element a_vec[i] enters row-i skew delay of i cycles; element b_vec[j] enters column-j skew delay of j cycles.
  - On cycles with no accepted beat, zeros are injected; the skew pipelines always advance. Bubbles therefore never corrupt results.
  - After the K-th accepted beat the FSM moves to FLUSH.
- **FLUSH:** runs for exactly 2*N_SIZE-1 cycles with zeros injected, so PE(N-1,N-1) completes its last MAC. Then moves to DRAIN.
- **PE behaviour:**
  - Each cycle: acc += a_in*b_in.
  - Forwards a to the right and b downward, each through one register.
- **Arithmetic:**
  - Product is 2*DATAWIDTH bits, sign- or zero-extended per SIGNED to ACCWIDTH.
  - Accumulation wraps modulo 2^ACCWIDTH; no saturation.
- **DRAIN:**
  - out_valid = 1, out_row = r, c_row = accumulators of row r, starting at r = 0.
  - r advances on out_valid && out_ready.
  - c_row and out_row stay stable while out_ready = 0.
  - After row N_SIZE-1 is accepted: done pulses and the FSM returns to IDLE.
- **Ignored inputs:**
  - start outside IDLE.
  - in_valid outside LOAD (in_ready = 0 there).
- **Reset (any time, including mid-job):** state = IDLE and all registers cleared.
  - Outputs: in_ready = 0, out_valid = 0, out_row = 0, c_row = 0, busy = 0, done = 0.

## Timing
- start sampled at edge t0; LOAD active from cycle t0+1.
- in_ready is a registered function of state and count; it does not combinationally depend on in_valid.
- Last beat accepted in cycle tL → FLUSH for cycles tL+1 … tL+2N_SIZE-1 → out_valid first high in cycle tL+2N_SIZE.
- With no stalls, the first result is at t0 + K + 2N_SIZE; N_SIZE rows then follow back-to-back with out_ready = 1.
- done is high in the cycle after the final row handshake, coincident with busy = 0.
- A new start is accepted in that same cycle or later.
- Input stalls extend LOAD one cycle per bubble; output stalls extend DRAIN one cycle per low out_ready.

## Test plan
- **Identity:** N=4, K=4, unsigned. A = I, B rows = {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, no stalls.
  - Required: rows equal B.
  - out_valid first at t0+12; done at t0+16.
- **Random unsigned, max values:** K=K_MAX=16, all operands 255.
  - Required: every element = 16·65025 = 1040400, fitting ACCWIDTH = 20 without wrap.
- **Signed:** SIGNED=1, K=2, a = −1 everywhere, b = 127 everywhere.
  - Required: every element = −254 in 20-bit two's complement (0xFFF02).
- **Backpressure:** random in_valid at 50% and out_ready toggled every cycle.
  - Required: results match the golden model; c_row is stable while stalled; exactly N_SIZE handshakes, then done.
- **Reset and k_len = 0:**
  - Assert rst_n low mid-LOAD. Required: all outputs zero immediately. A following job with K=3 is still correct.
  - Start with k_len = 0. Required: 4 all-zero rows, then done.
- **Ignored start and clamping:**
  - start asserted during DRAIN. Required: no effect.
  - k_len = 31 with K_MAX = 16. Required: exactly 16 beats accepted.
